// File: rtl/z2_cycle_ctrl_pkg.sv
// rtl/z2_cycle_ctrl_pkg.sv - shared Zorro II cycle state encoding
package z2_cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        Z2_IDLE  = 2'd0,
        Z2_START = 2'd1,
        Z2_DATA  = 2'd2,
        Z2_END   = 2'd3
    } z2_state_e;

endpackage

// File: rtl/z2_cycle_ctrl_sync.sv
// rtl/z2_cycle_ctrl_sync.sv - flop-chain synchroniser for asynchronous 68k strobes, resets to 1
module z2_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], d};
    end

    // Strobes are active-low, so reset to the negated level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '1;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/z2_cycle_ctrl.sv
// rtl/z2_cycle_ctrl.sv - Zorro II slave cycle controller: strobe sync, DTACK arbitration, timeout and abort
module z2_cycle_ctrl
    import z2_cycle_ctrl_pkg::*;
#(
    parameter int                     NUM_TARGETS    = 5,
    parameter int                     SYNC_STAGES    = 2,
    parameter logic [NUM_TARGETS-1:0] IMMED_MASK     = 5'b10010,
    parameter int                     TIMEOUT_CYCLES = 64,
    parameter int                     TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   MEMCLK,
    input  logic                   RESET,
    input  logic                   AS_n,
    input  logic                   UDS_n,
    input  logic                   LDS_n,
    input  logic                   RW,
    input  logic [NUM_TARGETS-1:0] sel,
    input  logic [NUM_TARGETS-1:0] ready,
    output logic                   as_n_sync,
    output logic                   uds_n_sync,
    output logic                   lds_n_sync,
    output logic                   rw_sync,
    output logic [1:0]             z2_state,
    output logic [NUM_TARGETS-1:0] tgt_onehot,
    output logic                   dtack,
    output logic                   timeout
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    // AS_n gets one extra stage so the data strobes are never seen ahead of it.
    z2_sync #(.DEPTH(SYNC_STAGES + 1)) u_sync_as  (.clk(MEMCLK), .rst(RESET), .d(AS_n),  .q(as_n_sync));
    z2_sync #(.DEPTH(SYNC_STAGES))     u_sync_uds (.clk(MEMCLK), .rst(RESET), .d(UDS_n), .q(uds_n_sync));
    z2_sync #(.DEPTH(SYNC_STAGES))     u_sync_lds (.clk(MEMCLK), .rst(RESET), .d(LDS_n), .q(lds_n_sync));
    z2_sync #(.DEPTH(SYNC_STAGES))     u_sync_rw  (.clk(MEMCLK), .rst(RESET), .d(RW),    .q(rw_sync));

    z2_state_e              state_q, state_d;
    logic [NUM_TARGETS-1:0] tgt_q, tgt_d;
    logic                   dtack_q, dtack_d;
    logic                   timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_TARGETS-1:0] sel_low;
    logic                   ack;

    // Lowest-index hit wins when decoders overlap.
    always_comb begin
        sel_low = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_low    = '0;
                sel_low[i] = 1'b1;
            end
        end
    end

    assign ack = |(tgt_q & (ready | IMMED_MASK));

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        dtack_d   = dtack_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            Z2_IDLE: begin
                if (!as_n_sync && |sel) begin
                    tgt_d   = sel_low;
                    cnt_d   = '0;
                    state_d = Z2_START;
                end
            end
            Z2_START, Z2_DATA: begin
                // Abort beats ack, and ack beats timeout.
                if (as_n_sync) begin
                    tgt_d   = '0;
                    dtack_d = 1'b0;
                    state_d = Z2_IDLE;
                end else if (state_q == Z2_DATA && ack) begin
                    dtack_d = 1'b1;
                    state_d = Z2_END;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = Z2_END;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == Z2_START && (!uds_n_sync || !lds_n_sync)) begin
                        state_d = Z2_DATA;
                    end
                end
            end
            Z2_END: begin
                if (as_n_sync) begin
                    dtack_d = 1'b0;
                    tgt_d   = '0;
                    state_d = Z2_IDLE;
                end
            end
            default: begin
                state_d = Z2_IDLE;
            end
        endcase
    end

    always_ff @(posedge MEMCLK) begin
        if (RESET) begin
            state_q   <= Z2_IDLE;
            tgt_q     <= '0;
            dtack_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            dtack_q   <= dtack_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign z2_state   = state_q;
    assign tgt_onehot = tgt_q;
    assign dtack      = dtack_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// tb/tb_z2_cycle_ctrl.sv - randomized bench for z2_cycle_ctrl against an event-time reference model
module tb_z2_cycle_ctrl;

    localparam int         S     = 2;
    localparam int         T     = 8;
    localparam int         N     = 5;
    localparam logic [4:0] IMMED = 5'b10010;
    localparam int         BIG   = 100000;

    logic       MEMCLK = 1'b0;
    logic       RESET  = 1'b1;
    logic       AS_n   = 1'b1;
    logic       UDS_n  = 1'b1;
    logic       LDS_n  = 1'b1;
    logic       RW     = 1'b1;
    logic [4:0] sel    = '0;
    logic [4:0] ready  = '0;
    logic       as_n_sync, uds_n_sync, lds_n_sync, rw_sync;
    logic [1:0] z2_state;
    logic [4:0] tgt_onehot;
    logic       dtack, timeout;

    z2_cycle_ctrl #(
        .NUM_TARGETS   (N),
        .SYNC_STAGES   (S),
        .IMMED_MASK    (IMMED),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .MEMCLK    (MEMCLK),
        .RESET     (RESET),
        .AS_n      (AS_n),
        .UDS_n     (UDS_n),
        .LDS_n     (LDS_n),
        .RW        (RW),
        .sel       (sel),
        .ready     (ready),
        .as_n_sync (as_n_sync),
        .uds_n_sync(uds_n_sync),
        .lds_n_sync(lds_n_sync),
        .rw_sync   (rw_sync),
        .z2_state  (z2_state),
        .tgt_onehot(tgt_onehot),
        .dtack     (dtack),
        .timeout   (timeout)
    );

    always #5 MEMCLK = ~MEMCLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction parameters; indices count clocks from the edge before AS_n falls.
    int         m_u, m_r, m_a, m_n_data, m_e_end, m_to_end;
    bit         m_acked, m_aborted, m_has, m_uu, m_ul;
    bit         m_rw = 1'b1;
    bit         m_rw_prev = 1'b1;
    logic [4:0] m_tgt;

    function automatic logic [4:0] lowest(input logic [4:0] v);
        logic [4:0] nv;
        nv = ~v;
        return v & (nv + 5'd1);
    endfunction

    task automatic calc();
        int c, ack_i, r_eff, n_start;
        n_start  = S + 2;
        c        = (n_start > m_u + S) ? n_start : m_u + S;
        m_n_data = (m_u < m_a && c <= m_a + S - 1) ? c + 1 : BIG;
        r_eff    = ((m_tgt & IMMED) != 0) ? 0 : m_r;
        ack_i    = (m_n_data > r_eff) ? m_n_data : r_eff;
        m_to_end = n_start + T;
        m_acked  = (ack_i + 1 <= m_to_end);
        m_e_end  = m_acked ? ack_i + 1 : m_to_end;
        m_aborted = (m_a + S + 1 < m_e_end);
    endtask

    function automatic logic [1:0] exp_state(input int i);
        if (!m_has || i < S + 2 || i >= m_a + S + 2) return 2'd0;
        if (m_aborted) return (i < m_n_data) ? 2'd1 : 2'd2;
        if (i < m_n_data && i < m_e_end) return 2'd1;
        if (i < m_e_end) return 2'd2;
        return 2'd3;
    endfunction

    task automatic run_txn(input logic [4:0] s, input bit uu, input bit ul, input int u,
                           input int r, input bit abort, input int hold, input bit rw);
        int         len;
        logic [4:0] rdy;
        logic [3:0] sy_exp;
        bit         in_win;
        m_has     = (s != 0);
        m_tgt     = lowest(s);
        m_u       = u;
        m_r       = r;
        m_uu      = uu;
        m_ul      = ul;
        m_rw_prev = m_rw;
        m_rw      = rw;
        if (!m_has) begin
            m_a = 1 + hold;
        end else begin
            m_a = BIG;
            calc();
            if (abort) m_a = $urandom_range(1, m_e_end - S - 2);
            else       m_a = m_e_end + hold;
        end
        calc();
        len = m_a + S + 4;
        for (int i = 0; i < len; i++) begin
            @(posedge MEMCLK);
            #1;
            AS_n  = (i >= m_a);
            UDS_n = !(uu && i >= u && i < m_a);
            LDS_n = !(ul && i >= u && i < m_a);
            RW    = rw;
            sel   = !m_has ? 5'd0 : (i <= S + 1) ? s : 5'($urandom);
            rdy   = 5'($urandom);
            if (m_has) begin
                if ((m_tgt & IMMED) != 0 || i < r) rdy = rdy & ~m_tgt;
                else                               rdy = rdy | m_tgt;
            end
            ready = rdy;
            @(negedge MEMCLK);
            in_win    = (i >= u + S && u < m_a && i <= m_a + S - 1);
            sy_exp[3] = !(i >= S + 1 && i <= m_a + S);
            sy_exp[2] = !(uu && in_win);
            sy_exp[1] = !(ul && in_win);
            sy_exp[0] = (i >= S) ? m_rw : m_rw_prev;
            chk("sync", {as_n_sync, uds_n_sync, lds_n_sync, rw_sync}, sy_exp);
            chk("state", z2_state, exp_state(i));
            chk("dtack", dtack, m_has && !m_aborted && m_acked && i >= m_e_end && i < m_a + S + 2);
            chk("timeout", timeout, m_has && !m_aborted && !m_acked && i == m_to_end);
            chk("tgt", tgt_onehot, (m_has && i >= S + 2 && i < m_a + S + 2) ? m_tgt : 5'd0);
        end
    endtask

    initial begin
        int k;
        RW = 1'b0;
        repeat (3) @(posedge MEMCLK);
        @(negedge MEMCLK);
        chk("rst_state", z2_state, 2'd0);
        chk("rst_sync", {as_n_sync, uds_n_sync, lds_n_sync, rw_sync}, 4'b1111);
        chk("rst_out", {tgt_onehot, dtack, timeout}, 7'd0);
        @(posedge MEMCLK);
        #1;
        RESET = 1'b0;
        RW    = 1'b1;
        repeat (S + 2) @(posedge MEMCLK);

        run_txn(5'b00001, 1'b1, 1'b0, 0, 8,   1'b0, 2, 1'b1);
        run_txn(5'b00010, 1'b0, 1'b1, 0, BIG, 1'b0, 1, 1'b1);
        run_txn(5'b10100, 1'b1, 1'b1, 1, 6,   1'b0, 0, 1'b0);
        run_txn(5'b00001, 1'b1, 1'b0, 0, BIG, 1'b0, 3, 1'b1);
        run_txn(5'b00001, 1'b1, 1'b0, 0, BIG, 1'b1, 0, 1'b1);
        run_txn(5'b00000, 1'b1, 1'b1, 0, 0,   1'b0, 2, 1'b1);

        for (int n = 0; n < 150; n++) begin
            logic [4:0] s;
            logic [1:0] ds;
            s  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ds = 2'($urandom_range(1, 3));
            run_txn(s, ds[0], ds[1], $urandom_range(0, 5),
                    ($urandom_range(0, 3) == 0) ? BIG : $urandom_range(0, 14),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset pulse mid-DATA with strobes still low: cycle drops and restarts.
        for (int i = 0; i < 12; i++) begin
            @(posedge MEMCLK);
            #1;
            AS_n  = 1'b0;
            UDS_n = 1'b0;
            LDS_n = 1'b1;
            sel   = 5'b00001;
            ready = 5'b00000;
            RESET = (i == 6);
            @(negedge MEMCLK);
            if (i == 6) chk("pre_rst_state", z2_state, 2'd2);
            if (i == 7) begin
                chk("mid_rst_state", z2_state, 2'd0);
                chk("mid_rst_sync", {as_n_sync, uds_n_sync, lds_n_sync, rw_sync}, 4'b1111);
                chk("mid_rst_out", {tgt_onehot, dtack, timeout}, 7'd0);
            end
            if (i == 10) chk("restart_idle", {as_n_sync, z2_state}, 3'b000);
            if (i == 11) chk("restart_start", {z2_state, tgt_onehot}, {2'd1, 5'b00001});
        end
        k = 0;
        repeat (S + 6) begin
            @(posedge MEMCLK);
            #1;
            AS_n  = 1'b1;
            UDS_n = 1'b1;
            k++;
        end
        @(negedge MEMCLK);
        chk("final_idle", {z2_state, dtack, timeout}, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
